// File: rtl/record_player_pkg.sv
// record_player_pkg
// Shared widths for the record/playback path. Every module of the record
// player imports this package so that the record memory, the sound interface
// and the note LEDs agree on field sizes.
//   REC_CNT_BITS  : record-memory address width (2**REC_CNT_BITS entries)
//   OCTAVE_BITS   : width of the octave field of a note
//   NOTE_BITS     : width of the note field (0 = rest, 1..NOTE_KEY_BITS = keys)
//   LENGTH_BITS   : width of the note-length field
//   NOTE_KEY_BITS : number of keys / note LEDs
package record_player_pkg;

    localparam int REC_CNT_BITS  = 3;
    localparam int OCTAVE_BITS   = 3;
    localparam int NOTE_BITS     = 4;
    localparam int LENGTH_BITS   = 3;
    localparam int NOTE_KEY_BITS = 12;

endpackage

// File: rtl/record_player_light.sv
// record_player_light
// One-hot key decode for the note LEDs.
//   en   in  : LEDs are lit only while en is high
//   note in  : note number; 0 is a rest and lights nothing, key k lights bit k-1
//   led  out : one-hot (or all-zero) key pattern
module record_player_light
    import record_player_pkg::*;
(
    input  logic                     en,
    input  logic [NOTE_BITS-1:0]     note,
    output logic [NOTE_KEY_BITS-1:0] led
);

    genvar gi;
    generate
        for (gi = 0; gi < NOTE_KEY_BITS; gi++) begin : g_key
            assign led[gi] = en && (note == NOTE_BITS'(gi + 1));
        end
    endgenerate

endmodule

// File: rtl/record_player.sv
// record_player
// Plays back the recorded note list through the Sound block, one note at a
// time, with a silent gap between notes.
//   clk, rst          : clock, asynchronous active-high reset
//   start / stop      : single-cycle begin-from-entry-0 / abort requests
//   pause             : level, holds off fetching the next note
//   loop              : level, sampled at end of list (1 = restart at entry 0)
//   rec_len           : number of valid recorded entries
//   rd_addr, rd_*     : record-memory read port (combinational data)
//   snd_en, snd_*     : note presented to Sound; snd_over from Sound (1 = idle)
//   busy, done        : not-IDLE indicator, end-of-playback pulse
//   note_led          : one-hot key of the sounding note
module record_player
    import record_player_pkg::*;
#(
    parameter int GAP_CYCLES   = 100000,
    parameter int OVER_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     loop,
    input  logic [REC_CNT_BITS:0]    rec_len,
    output logic [REC_CNT_BITS-1:0]  rd_addr,
    input  logic [OCTAVE_BITS-1:0]   rd_octave,
    input  logic [NOTE_BITS-1:0]     rd_note,
    input  logic [LENGTH_BITS-1:0]   rd_length,
    output logic                     snd_en,
    output logic [OCTAVE_BITS-1:0]   snd_octave,
    output logic [NOTE_BITS-1:0]     snd_note,
    output logic [LENGTH_BITS-1:0]   snd_length,
    input  logic                     snd_over,
    output logic                     busy,
    output logic                     done,
    output logic [NOTE_KEY_BITS-1:0] note_led
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_KICK,
        ST_PLAY,
        ST_GAP,
        ST_FIN
    } state_t;

    // Counters are sized to hold 0..PARAM-1; a 1-bit floor keeps degenerate
    // parameter values (0 or 1) legal.
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMO_W      = (OVER_TIMEOUT > 1) ? $clog2(OVER_TIMEOUT) : 1;
    // GAP_CYCLES = 0 still spends one cycle in GAP.
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int TMO_LAST_I = (OVER_TIMEOUT > 0) ? OVER_TIMEOUT - 1 : 0;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LAST_I);

    state_t                   state_q, state_d;
    logic [REC_CNT_BITS-1:0]  idx_q, idx_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [OCTAVE_BITS-1:0]   oct_q, oct_d;
    logic [NOTE_BITS-1:0]     note_q, note_d;
    logic [LENGTH_BITS-1:0]   len_q, len_d;
    logic                     last_entry;

    // End of list when idx+1 >= rec_len, evaluated one bit wider than idx so
    // a full memory (rec_len = 2**REC_CNT_BITS) compares correctly. This also
    // covers rec_len having shrunk below the current position.
    assign last_entry = (({1'b0, idx_q} + (REC_CNT_BITS + 1)'(1)) >= rec_len);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = '0;
        tmo_d   = '0;
        oct_d   = oct_q;
        note_d  = note_q;
        len_d   = len_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = (rec_len != '0) ? ST_FETCH : ST_FIN;
                end
            end
            ST_FETCH: begin
                if (!pause) begin
                    oct_d   = rd_octave;
                    note_d  = rd_note;
                    len_d   = rd_length;
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                // Sound that never acknowledges must not stall playback.
                if (!snd_over) begin
                    state_d = ST_PLAY;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_GAP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_PLAY: begin
                if (snd_over) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (!last_entry) begin
                        idx_d   = idx_q + REC_CNT_BITS'(1);
                        state_d = ST_FETCH;
                    end else if (loop && (rec_len != '0)) begin
                        idx_d   = '0;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything evaluated above.
        if (stop) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            gap_d   = '0;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            oct_q   <= '0;
            note_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            oct_q   <= oct_d;
            note_q  <= note_d;
            len_q   <= len_d;
        end
    end

    // Outputs decode straight from the state register so that reset clears
    // them without waiting for a clock edge.
    assign snd_en     = (state_q == ST_KICK) || (state_q == ST_PLAY);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign rd_addr    = idx_q;
    assign snd_octave = oct_q;
    assign snd_note   = note_q;
    assign snd_length = len_q;

    record_player_light u_light (
        .en   (snd_en),
        .note (snd_note),
        .led  (note_led)
    );

endmodule

// File: tb/tb_record_player.sv
// tb_record_player
// Directed bench for record_player with GAP_CYCLES=4, OVER_TIMEOUT=16.
// A small Sound model pulls snd_over low for 20 cycles after each snd_en
// rise (or never, when sound_dead is set). A monitor logs every snd_en burst.
module tb_record_player;
    import record_player_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic                     stop = 1'b0;
    logic                     pause = 1'b0;
    logic                     loop = 1'b0;
    logic [REC_CNT_BITS:0]    rec_len = '0;
    logic [REC_CNT_BITS-1:0]  rd_addr;
    logic [OCTAVE_BITS-1:0]   rd_octave;
    logic [NOTE_BITS-1:0]     rd_note;
    logic [LENGTH_BITS-1:0]   rd_length;
    logic                     snd_en;
    logic [OCTAVE_BITS-1:0]   snd_octave;
    logic [NOTE_BITS-1:0]     snd_note;
    logic [LENGTH_BITS-1:0]   snd_length;
    logic                     snd_over = 1'b1;
    logic                     busy;
    logic                     done;
    logic [NOTE_KEY_BITS-1:0] note_led;

    int n_checks = 0;
    int n_errors = 0;

    // Record memory and the hand-decoded LED pattern of each entry.
    logic [OCTAVE_BITS-1:0]   mem_oct  [8];
    logic [NOTE_BITS-1:0]     mem_note [8];
    logic [LENGTH_BITS-1:0]   mem_len  [8];
    logic [NOTE_KEY_BITS-1:0] exp_led  [8];

    assign rd_octave = mem_oct[rd_addr];
    assign rd_note   = mem_note[rd_addr];
    assign rd_length = mem_len[rd_addr];

    always #5 clk = ~clk;

    record_player #(
        .GAP_CYCLES   (4),
        .OVER_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .loop       (loop),
        .rec_len    (rec_len),
        .rd_addr    (rd_addr),
        .rd_octave  (rd_octave),
        .rd_note    (rd_note),
        .rd_length  (rd_length),
        .snd_en     (snd_en),
        .snd_octave (snd_octave),
        .snd_note   (snd_note),
        .snd_length (snd_length),
        .snd_over   (snd_over),
        .busy       (busy),
        .done       (done),
        .note_led   (note_led)
    );

    // Sound model
    bit   sound_dead = 1'b0;
    int   over_cnt = 0;
    logic en_prev = 1'b0;

    always @(negedge clk) begin
        if (rst || stop) begin
            snd_over <= 1'b1;
            over_cnt <= 0;
            en_prev  <= 1'b0;
        end else begin
            en_prev <= snd_en;
            if (over_cnt != 0) begin
                over_cnt <= over_cnt - 1;
                if (over_cnt == 1) snd_over <= 1'b1;
            end else if (snd_en && !en_prev && !sound_dead) begin
                snd_over <= 1'b0;
                over_cnt <= 20;
            end
        end
    end

    // Burst / done monitor
    logic                     mon_prev = 1'b0;
    int                       n_done = 0;
    logic [OCTAVE_BITS-1:0]   q_oct  [$];
    logic [NOTE_BITS-1:0]     q_note [$];
    logic [LENGTH_BITS-1:0]   q_len  [$];
    logic [NOTE_KEY_BITS-1:0] q_led  [$];

    always @(negedge clk) begin
        mon_prev <= snd_en;
        if (snd_en && !mon_prev) begin
            q_oct.push_back(snd_octave);
            q_note.push_back(snd_note);
            q_len.push_back(snd_length);
            q_led.push_back(note_led);
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_bursts(input int n, input int bound, input string tag);
        int c = 0;
        while (q_note.size() < n && c < bound) begin
            tick();
            c++;
        end
        check_eq(tag, (q_note.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int c = 0;
        while (busy && c < bound) begin
            tick();
            c++;
        end
        check_eq(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int d0;
        int cnt;
        int c;
        int max_addr;

        // entries: (octave, note, length)
        mem_oct[0] = 3'd4; mem_note[0] = 4'd1;  mem_len[0] = 3'd2; exp_led[0] = 12'h001;
        mem_oct[1] = 3'd4; mem_note[1] = 4'd3;  mem_len[1] = 3'd2; exp_led[1] = 12'h004;
        mem_oct[2] = 3'd5; mem_note[2] = 4'd5;  mem_len[2] = 3'd1; exp_led[2] = 12'h010;
        mem_oct[3] = 3'd3; mem_note[3] = 4'd7;  mem_len[3] = 3'd4; exp_led[3] = 12'h040;
        mem_oct[4] = 3'd2; mem_note[4] = 4'd9;  mem_len[4] = 3'd3; exp_led[4] = 12'h100;
        mem_oct[5] = 3'd6; mem_note[5] = 4'd11; mem_len[5] = 3'd5; exp_led[5] = 12'h400;
        mem_oct[6] = 3'd1; mem_note[6] = 4'd12; mem_len[6] = 3'd6; exp_led[6] = 12'h800;
        mem_oct[7] = 3'd7; mem_note[7] = 4'd0;  mem_len[7] = 3'd7; exp_led[7] = 12'h000;

        // Reset state
        repeat (3) tick();
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_snd_en", {31'd0, snd_en}, 32'd0);
        check_eq("rst_note_led", {20'd0, note_led}, 32'd0);
        check_eq("rst_rd_addr", {29'd0, rd_addr}, 32'd0);
        check_eq("rst_snd_note", {28'd0, snd_note}, 32'd0);
        rst = 1'b0;
        tick();

        // Three-note playback with latency checks
        rec_len = 4'd3; loop = 1'b0;
        b0 = q_note.size(); d0 = n_done;
        pulse_start();
        check_eq("lat_fetch_busy", {31'd0, busy}, 32'd1);
        check_eq("lat_fetch_snd_en", {31'd0, snd_en}, 32'd0);
        check_eq("lat_fetch_rd_addr", {29'd0, rd_addr}, 32'd0);
        tick();
        check_eq("lat_kick_snd_en", {31'd0, snd_en}, 32'd1);
        check_eq("lat_kick_octave", {29'd0, snd_octave}, 32'd4);
        check_eq("lat_kick_note", {28'd0, snd_note}, 32'd1);
        check_eq("lat_kick_length", {29'd0, snd_length}, 32'd2);
        check_eq("lat_kick_led", {20'd0, note_led}, 32'h001);
        wait_idle(400, "play3_idle");
        check_eq("play3_bursts", q_note.size() - b0, 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (q_note.size() > b0 + i) begin
                check_eq($sformatf("play3_oct%0d", i), {29'd0, q_oct[b0+i]}, {29'd0, mem_oct[i]});
                check_eq($sformatf("play3_note%0d", i), {28'd0, q_note[b0+i]}, {28'd0, mem_note[i]});
                check_eq($sformatf("play3_len%0d", i), {29'd0, q_len[b0+i]}, {29'd0, mem_len[i]});
                check_eq($sformatf("play3_led%0d", i), {20'd0, q_led[b0+i]}, {20'd0, exp_led[i]});
            end
        end
        check_eq("play3_done", n_done - d0, 32'd1);
        check_eq("play3_gap_led", {20'd0, note_led}, 32'd0);

        // Empty list: done straight away, no sound
        rec_len = 4'd0;
        b0 = q_note.size();
        pulse_start();
        check_eq("empty_done", {31'd0, done}, 32'd1);
        check_eq("empty_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("empty_done_end", {31'd0, done}, 32'd0);
        check_eq("empty_busy_end", {31'd0, busy}, 32'd0);
        check_eq("empty_bursts", q_note.size() - b0, 32'd0);

        // Looping two entries, then drop loop during entry 1
        rec_len = 4'd2; loop = 1'b1;
        b0 = q_note.size(); d0 = n_done;
        pulse_start();
        wait_bursts(b0 + 4, 400, "loop_4_bursts");
        loop = 1'b0;
        wait_idle(200, "loop_idle");
        check_eq("loop_bursts", q_note.size() - b0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (q_note.size() > b0 + i)
                check_eq($sformatf("loop_note%0d", i), {28'd0, q_note[b0+i]}, {28'd0, mem_note[i % 2]});
        end
        check_eq("loop_done", n_done - d0, 32'd1);

        // Stop during PLAY of entry 1
        rec_len = 4'd3; loop = 1'b0;
        b0 = q_note.size(); d0 = n_done;
        pulse_start();
        wait_bursts(b0 + 2, 200, "stop_reach_entry1");
        repeat (3) tick();
        check_eq("stop_pre_snd_en", {31'd0, snd_en}, 32'd1);
        check_eq("stop_pre_note", {28'd0, snd_note}, 32'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stop_snd_en", {31'd0, snd_en}, 32'd0);
        check_eq("stop_busy", {31'd0, busy}, 32'd0);
        check_eq("stop_rd_addr", {29'd0, rd_addr}, 32'd0);
        repeat (10) tick();
        check_eq("stop_no_done", n_done - d0, 32'd0);
        pulse_start();
        tick();
        check_eq("restart_snd_en", {31'd0, snd_en}, 32'd1);
        check_eq("restart_note", {28'd0, snd_note}, 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("restart_stop_busy", {31'd0, busy}, 32'd0);

        // Pause before entry 2, then Sound that never answers
        rec_len = 4'd3;
        b0 = q_note.size(); d0 = n_done;
        pulse_start();
        wait_bursts(b0 + 2, 200, "pause_reach_entry1");
        pause = 1'b1;
        c = 0;
        while (rd_addr != 3'd2 && c < 100) begin
            tick();
            c++;
        end
        check_eq("pause_at_entry2", {29'd0, rd_addr}, 32'd2);
        cnt = 0;
        repeat (50) begin
            tick();
            if (snd_en) cnt++;
        end
        check_eq("pause_silent_cycles", cnt, 32'd0);
        check_eq("pause_busy", {31'd0, busy}, 32'd1);
        sound_dead = 1'b1;
        pause = 1'b0;
        cnt = 0;
        c = 0;
        while (busy && c < 200) begin
            tick();
            if (snd_en) cnt++;
            c++;
        end
        check_eq("timeout_idle", {31'd0, busy}, 32'd0);
        check_eq("timeout_en_cycles", cnt, 32'd16);
        check_eq("timeout_bursts", q_note.size() - b0, 32'd3);
        if (q_note.size() > b0 + 2)
            check_eq("timeout_note", {28'd0, q_note[b0+2]}, 32'd5);
        check_eq("timeout_done", n_done - d0, 32'd1);
        sound_dead = 1'b0;

        // Reset mid-PLAY
        rec_len = 4'd3;
        b0 = q_note.size();
        pulse_start();
        wait_bursts(b0 + 1, 100, "rst_reach_play");
        repeat (2) tick();
        check_eq("rst_pre_snd_en", {31'd0, snd_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_async_snd_en", {31'd0, snd_en}, 32'd0);
        check_eq("rst_async_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_async_led", {20'd0, note_led}, 32'd0);
        check_eq("rst_async_note", {28'd0, snd_note}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
        check_eq("rst_no_resume_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_no_resume_bursts", q_note.size() - b0, 32'd1);

        // rec_len shrinks while entry 1 plays
        rec_len = 4'd3;
        b0 = q_note.size(); d0 = n_done;
        pulse_start();
        wait_bursts(b0 + 2, 200, "shrink_reach_entry1");
        rec_len = 4'd1;
        wait_idle(200, "shrink_idle");
        check_eq("shrink_bursts", q_note.size() - b0, 32'd2);
        check_eq("shrink_done", n_done - d0, 32'd1);

        // Full memory
        rec_len = 4'd8; loop = 1'b0;
        b0 = q_note.size(); d0 = n_done;
        pulse_start();
        max_addr = 0;
        c = 0;
        while (busy && c < 800) begin
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            tick();
            c++;
        end
        check_eq("full_idle", {31'd0, busy}, 32'd0);
        check_eq("full_max_addr", max_addr, 32'd7);
        check_eq("full_bursts", q_note.size() - b0, 32'd8);
        if (q_note.size() > b0 + 7) begin
            check_eq("full_last_oct", {29'd0, q_oct[b0+7]}, 32'd7);
            check_eq("full_last_note", {28'd0, q_note[b0+7]}, 32'd0);
            check_eq("full_last_led", {20'd0, q_led[b0+7]}, {20'd0, exp_led[7]});
        end
        if (q_note.size() > b0 + 6)
            check_eq("full_key12_led", {20'd0, q_led[b0+6]}, 32'h800);
        check_eq("full_done", n_done - d0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/record_player.md
RECORD_PLAYER -- requirements
Module: record_player

Interface
REQ-001 Parameter GAP_CYCLES, default 100000, silent clk cycles inserted between consecutive notes.
REQ-002 Parameter OVER_TIMEOUT, default 16, max cycles to wait for snd_over to fall after snd_en rises.
REQ-003 clk  in  1  system clock; one clock domain.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to begin playback from entry 0.
REQ-006 stop  in  1  single-cycle abort request.
REQ-007 pause  in  1  level; while high, the next note is not started.
REQ-008 loop  in  1  level; sampled at end of list: 1 restarts at entry 0, 0 finishes.
REQ-009 rec_len  in  REC_CNT_BITS+1  number of valid recorded entries, 0..2^REC_CNT_BITS.
REQ-010 rd_addr  out  REC_CNT_BITS  record-memory read address.
REQ-011 rd_octave / rd_note / rd_length  in  OCTAVE_BITS / NOTE_BITS / LENGTH_BITS  combinational read data at rd_addr.
REQ-012 snd_en  out  1  Sound enable.
REQ-013 snd_octave / snd_note / snd_length  out  OCTAVE_BITS / NOTE_BITS / LENGTH_BITS  note presented to Sound.
REQ-014 snd_over  in  1  from Sound: 1 = idle/finished, 0 = note sounding.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  single-cycle pulse when playback finishes normally.
REQ-017 note_led  out  NOTE_KEY_BITS  one-hot of snd_note while snd_en is high (note 0 = rest -> all zero), else zero.

Function
REQ-018 FSM states IDLE, FETCH, KICK, PLAY, GAP, FIN; encoding free.
REQ-019 IDLE: on start with rec_len!=0 -> FETCH, idx=0; on start with rec_len==0 -> FIN; start while not IDLE is ignored.
REQ-020 rd_addr SHALL equal idx at all times.
REQ-021 FETCH: if pause high, stay; else latch rd_* into snd_* registers -> KICK.
REQ-022 KICK: snd_en=1; when snd_over==0 -> PLAY; if OVER_TIMEOUT cycles elapse with snd_over still 1 -> GAP (note skipped, no stall).
REQ-023 PLAY: snd_en=1 held; when snd_over returns to 1 -> snd_en=0, -> GAP.
REQ-024 GAP: count GAP_CYCLES with snd_en=0; at terminal count, if idx==rec_len-1 then (loop ? idx=0, FETCH : FIN), else idx=idx+1, FETCH.
REQ-025 FIN: assert done for exactly one cycle -> IDLE.
REQ-026 Latency: start at cycle N -> FETCH at N+1 -> snd_en high at N+2 (pause low).
REQ-027 stop in any state -> IDLE next cycle, snd_en=0, idx=0, no done pulse; stop has priority over a simultaneous start or terminal GAP count.
REQ-028 pause affects only FETCH; a sounding note and a running GAP always complete.
REQ-029 rec_len==2^REC_CNT_BITS: idx reaches 2^REC_CNT_BITS-1, then wraps to 0 (loop) or finishes; idx never exceeds rec_len-1.
REQ-030 rec_len sampled at each GAP terminal count; if it has dropped to <= idx, finish as at end of list.
REQ-031 GAP counter and timeout counter widths = clog2 of their parameters; GAP_CYCLES=0 means GAP lasts exactly 1 cycle.

Reset
REQ-032 On rst: state IDLE, idx=0, snd_en=0, snd_octave/snd_note/snd_length=0, busy=0, done=0, note_led=0, counters=0.
REQ-033 rst asserted mid-note forces snd_en low asynchronously; playback does not resume after rst release.

Structure
REQ-034 REC_CNT_BITS, OCTAVE_BITS, NOTE_BITS, LENGTH_BITS, NOTE_KEY_BITS come from the shared Constants.vh; state encoding local.
REQ-035 note_led decode reuses existing Light sub-module (Light(snd_en, snd_note, note_led)); no other sub-modules.

Verification
REQ-036 rec_len=3, entries (4,1,2),(4,3,2),(5,5,1), Sound model over low 20 cycles, GAP_CYCLES=4 -> three snd_en bursts with matching snd_*, one done pulse, busy drops.
REQ-037 rec_len=0, start -> done at N+1, snd_en never high.
REQ-038 rec_len=2, loop=1 -> sequence 0,1,0,1...; drop loop during entry 1 -> done after entry 1 GAP.
REQ-039 stop asserted during PLAY of entry 1 -> snd_en=0 and busy=0 next cycle, no done, next start begins at entry 0.
REQ-040 pause high before entry 2 FETCH for 50 cycles -> snd_en stays 0 for those cycles, entry 2 plays on release; Sound model never drops over -> note skipped after 16 cycles.
REQ-041 rst pulsed mid-PLAY -> all outputs zero immediately; rec_len=2^REC_CNT_BITS full run ends at idx 2^REC_CNT_BITS-1.
